// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered read port, threshold flags and occupancy count.
// Define FIFO_ERR_EN to build in sticky overflow/underflow reporting on `error`.
module fifo_param #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  input  logic [ADDR_W:0]   al_empty_in,
  input  logic [ADDR_W:0]   al_full_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              al_empty,
  output logic              al_full,
  output logic              pause,
  output logic [ADDR_W:0]   count,
  output logic              error
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic              wr_ok, rd_ok;

  // Flags decode only the registered count and the live thresholds.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign al_empty   = (count <= al_empty_in);
  assign al_full    = (count >= al_full_in);
  assign pause      = al_full;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_ok = fifo_wr & (~fifo_full | fifo_rd);
  assign rd_ok = fifo_rd & ~fifo_empty;

  // Storage is never cleared; stale words are unreachable after reset.
  always_ff @(posedge clk) begin
    if (!RESET && wr_ok) mem[wp] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) begin
        rp       <= rp + 1'b1;
        data_out <= mem[rp];
      end
      valid_out <= rd_ok;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (RESET) err_q <= 1'b0;
    else if ((fifo_wr & fifo_full & ~fifo_rd) | (fifo_rd & fifo_empty)) err_q <= 1'b1;
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_fifo_param;
  localparam int DW = 6, AW = 3, DEPTH = 8;
`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          fifo_wr = 1'b0, fifo_rd = 1'b0;
  logic [AW:0]   al_empty_in = 4'd2, al_full_in = 4'd6;
  logic [DW-1:0] data_out;
  logic          valid_out, fifo_empty, fifo_full, al_empty, al_full, pause, error;
  logic [AW:0]   count;

  fifo_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .RESET(RESET), .data_in(data_in), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .al_empty_in(al_empty_in), .al_full_in(al_full_in), .data_out(data_out),
    .valid_out(valid_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .al_empty(al_empty), .al_full(al_full), .pause(pause), .count(count), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: a plain queue of words plus the read register and sticky flag.
  int            q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_valid = 1'b0, m_err = 1'b0;

  typedef struct {
    bit            rst, wr, rd;
    logic [DW-1:0] din;
    int            cnt;
    bit            v;
    logic [DW-1:0] d;
    bit            err;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit wr, input bit rd, input logic [DW-1:0] din);
    bit rd_ok, wr_ok;
    if (rst) begin
      q.delete(); m_dout = '0; m_valid = 0; m_err = 0;
      return;
    end
    rd_ok = rd && q.size() > 0;
    wr_ok = wr && (q.size() < DEPTH || rd);
    if ((wr && q.size() == DEPTH && !rd) || (rd && q.size() == 0)) m_err = ERR_EN;
    if (rd_ok) m_dout = DW'(q.pop_front());
    m_valid = rd_ok;
    if (wr_ok) q.push_back(int'(din));
  endtask

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cycle(input bit rst, input bit wr, input bit rd, input logic [DW-1:0] din);
    RESET = rst; fifo_wr = wr; fifo_rd = rd; data_in = din;
    @(posedge clk);
    model_step(rst, wr, rd, din);
    @(negedge clk);
    RESET = 0; fifo_wr = 0; fifo_rd = 0;
  endtask

  task automatic check_flags(input string tag, input int c);
    chk({tag, ".empty"},    fifo_empty, c == 0);
    chk({tag, ".full"},     fifo_full,  c == DEPTH);
    chk({tag, ".al_empty"}, al_empty,   c <= int'(al_empty_in));
    chk({tag, ".al_full"},  al_full,    c >= int'(al_full_in));
    chk({tag, ".pause"},    pause,      c >= int'(al_full_in));
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, count, q.size());
    check_flags(tag, q.size());
    chk({tag, ".valid"}, valid_out, m_valid);
    chk({tag, ".dout"},  data_out,  m_dout);
    chk({tag, ".error"}, error,     m_err);
  endtask

  function automatic void add(bit rst, bit wr, bit rd, logic [DW-1:0] din,
                              int cnt, bit v, logic [DW-1:0] d, bit err);
    vec_t t;
    t.rst = rst; t.wr = wr; t.rd = rd; t.din = din;
    t.cnt = cnt; t.v = v; t.d = d; t.err = err;
    tv.push_back(t);
  endfunction

  initial begin
    // reset
    add(1,0,0,0,        0,0,0,0);
    add(1,0,0,0,        0,0,0,0);
    // single word
    add(0,1,0,6'b010010, 1,0,0,0);
    add(0,0,1,0,        0,1,6'b010010,0);
    // streaming from empty: first read rejected (underflow)
    add(0,1,1,6'b100100, 1,0,6'b010010,1);
    add(0,1,1,6'b110110, 1,1,6'b100100,1);
    add(0,1,1,6'b010100, 1,1,6'b110110,1);
    add(0,1,1,6'b110000, 1,1,6'b010100,1);
    add(0,0,1,0,        0,1,6'b110000,1);
    add(1,0,0,0,        0,0,0,0);
    // fill 0..7, then dropped 9th write
    for (int i = 0; i < 8; i++) add(0,1,0,DW'(i), i+1,0,0,0);
    add(0,1,0,6'b001000, 8,0,0,1);
    // drain, then one underflowing read that holds data_out
    for (int i = 0; i < 8; i++) add(0,0,1,0, 7-i,1,DW'(i),1);
    add(0,0,1,0,        0,0,6'd7,1);
    // refill across the pointer wrap
    add(0,1,0,6'd10,    1,0,6'd7,1);
    add(0,1,0,6'd11,    2,0,6'd7,1);
    add(0,1,0,6'd12,    3,0,6'd7,1);
    add(0,1,1,6'd13,    3,1,6'd10,1);
    add(0,0,1,0,        2,1,6'd11,1);

    @(negedge clk);
    foreach (tv[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      cycle(tv[k].rst, tv[k].wr, tv[k].rd, tv[k].din);
      chk({tag, ".count"}, count, tv[k].cnt);
      check_flags(tag, tv[k].cnt);
      chk({tag, ".valid"}, valid_out, tv[k].v);
      chk({tag, ".dout"},  data_out,  tv[k].d);
      chk({tag, ".error"}, error,     tv[k].err & ERR_EN);
    end

    // rd+wr while full keeps count at depth and pops the oldest word
    cycle(1,0,0,0);
    for (int i = 0; i < 8; i++) cycle(0,1,0,DW'(20+i));
    chk("full.count", count, 8);
    cycle(0,1,1,6'd40);
    chk("fullrw.count", count, 8);
    chk("fullrw.full",  fifo_full, 1);
    chk("fullrw.valid", valid_out, 1);
    chk("fullrw.dout",  data_out, 20);
    chk("fullrw.error", error, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0,0,1,0);
      chk("fullrw.drain", data_out, (i == 7) ? 40 : 21+i);
    end
    chk("fullrw.empty", fifo_empty, 1);

    // reset mid-operation with a concurrent write discards everything
    for (int i = 0; i < 5; i++) cycle(0,1,0,DW'(50+i));
    chk("midrst.pre", count, 5);
    cycle(1,1,0,6'd63);
    chk("midrst.count", count, 0);
    chk("midrst.empty", fifo_empty, 1);
    chk("midrst.error", error, 0);
    cycle(0,0,1,0);
    chk("midrst.valid", valid_out, 0);
    chk("midrst.count2", count, 0);

    // threshold changes act in the same cycle, unsigned compare
    al_full_in = 4'd0; al_empty_in = 4'd15;
    #1;
    chk("thr.al_full0",  al_full, 1);
    chk("thr.pause0",    pause, 1);
    chk("thr.al_empty15", al_empty, 1);
    al_full_in = 4'd9;
    #1;
    chk("thr.al_full9",  al_full, 0);
    @(negedge clk);

    // randomized traffic against the queue model
    for (int n = 0; n < 1500; n++) begin
      int mode;
      mode = n / 300;
      if ($urandom_range(15) == 0) begin
        al_empty_in = 4'($urandom_range(9));
        al_full_in  = 4'($urandom_range(9));
      end
      cycle($urandom_range(99) == 0,
            $urandom_range(99) < ((mode % 2) ? 75 : 40),
            $urandom_range(99) < ((mode % 2) ? 40 : 70),
            DW'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
